// File: rtl/sng_pkg.sv
// sng_bank shared types and helpers.
// State enum, LFSR tap table and rotate helper.
package sng_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Low-order terms of a primitive polynomial, bit m = x^m
  function automatic logic [15:0] lfsr_taps(input int width);
    logic [15:0] t;
    t = 16'h0003;
    case (width)
      3:  t = 16'h0003;
      4:  t = 16'h0003;
      5:  t = 16'h0005;
      6:  t = 16'h0003;
      7:  t = 16'h0003;
      8:  t = 16'h001D;
      9:  t = 16'h0011;
      10: t = 16'h0009;
      11: t = 16'h0005;
      12: t = 16'h0053;
      13: t = 16'h001B;
      14: t = 16'h002B;
      15: t = 16'h0003;
      16: t = 16'h002D;
      default: t = 16'h0003;
    endcase
    return t;
  endfunction

  // Rotate the low 'width' bits of v left by amt
  function automatic logic [15:0] rotl(
    input logic [15:0] v,
    input int amt,
    input int width
  );
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < width)
        r[4'((i + amt) % width)] = v[4'(i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/sng_lfsr.sv
// Fibonacci right-shift LFSR with load and enable.
// The load value is forced nonzero so the register never locks up.
module sng_lfsr
  import sng_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int unsigned SEED = 'h1A
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  localparam logic [15:0] TAPS_ALL = lfsr_taps(WIDTH);
  localparam logic [WIDTH-1:0] TAPS = TAPS_ALL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] S0 = SEED[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SEED_NZ =
    (S0 == '0) ? WIDTH'(1) : S0;

  // Seed on reset or frame start, otherwise shift in parity
  always_ff @(posedge clk) begin
    if (rst || load)
      q <= SEED_NZ;
    else if (en)
      q <= {^(q & TAPS), q[WIDTH-1:1]};
  end

endmodule

// File: rtl/sng_bank.sv
// Multi-channel stochastic number generator bank.
// Optional SNG_POPCOUNT_EN adds per-channel ones counters.
module sng_bank
  import sng_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NCH = 4,
  parameter int unsigned SEED = 'h1A,
  parameter int ROT_STRIDE = 3,
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [CW-1:0]    ld_ch,
  input  logic [WIDTH-1:0] ld_value,
  output logic             bit_valid,
  output logic [NCH-1:0]   y
`ifdef SNG_POPCOUNT_EN
  ,output logic [NCH*WIDTH-1:0] ones_cnt
`endif
);

  localparam logic [WIDTH-1:0] LAST =
    WIDTH'((1 << WIDTH) - 2);

  state_t state, state_nx;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] lfsr;
  logic [WIDTH-1:0] val [NCH];
  logic go, run;

  assign go  = (state == IDLE) && start;
  assign run = (state == RUN);

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign ld_ready  = (state == IDLE);
  assign bit_valid = run;

  sng_lfsr #(
    .WIDTH(WIDTH),
    .SEED (SEED)
  ) u_lfsr (
    .clk (clk),
    .rst (rst),
    .load(go),
    .en  (run),
    .q   (lfsr)
  );

  // State register and frame bit counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_nx;
      if (go)
        count <= '0;
      else if (run)
        count <= count + 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (count == LAST) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Value registers; writes to missing channels are dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++)
        val[i] <= '0;
    end else if (ld_valid && ld_ready
                 && int'(ld_ch) < NCH) begin
      val[ld_ch] <= ld_value;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    localparam int ROT = (i * ROT_STRIDE) % WIDTH;
    logic [15:0] r;
    assign r    = rotl(16'(lfsr), ROT, WIDTH);
    assign y[i] = run && (r <= 16'(val[i]));
  end

`ifdef SNG_POPCOUNT_EN
  logic [WIDTH-1:0] cnt [NCH];

  // Ones counters clear on start and hold after the frame
  always_ff @(posedge clk) begin
    if (rst || go) begin
      for (int i = 0; i < NCH; i++)
        cnt[i] <= '0;
    end else if (run) begin
      for (int i = 0; i < NCH; i++)
        cnt[i] <= cnt[i] + WIDTH'(y[i]);
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_pc
    assign ones_cnt[i*WIDTH +: WIDTH] = cnt[i];
  end
`endif

endmodule

// File: tb/tb_sng_bank.sv
// Directed self-checking bench for sng_bank.
// WIDTH=8, NCH=4; popcount checks when SNG_POPCOUNT_EN.
module tb_sng_bank;

  logic clk = 0;
  logic rst, start, ld_valid;
  logic busy, done, ld_ready, bit_valid;
  logic [1:0] ld_ch;
  logic [7:0] ld_value;
  logic [3:0] y;
`ifdef SNG_POPCOUNT_EN
  logic [31:0] ones_cnt;
`endif

  int total = 0;
  int bad = 0;
  int n;
  int ones [4];
  int diff01;
  logic [3:0] f0, f1;
  logic mid_ready;

  always #5 clk = ~clk;

  sng_bank dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .ld_valid (ld_valid),
    .ld_ready (ld_ready),
    .ld_ch    (ld_ch),
    .ld_value (ld_value),
    .bit_valid(bit_valid),
    .y        (y)
`ifdef SNG_POPCOUNT_EN
    ,.ones_cnt(ones_cnt)
`endif
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [1:0] c, input logic [7:0] v);
    ld_valid = 1; ld_ch = c; ld_value = v;
    tick();
    ld_valid = 0;
  endtask

  task automatic frame(input bit ld, input logic [7:0] v,
                       input bit mid, input int rst_at);
    start = 1;
    if (ld) begin
      ld_valid = 1; ld_ch = 2; ld_value = v;
    end
    tick();
    start = 0; ld_valid = 0;
    n = 0; diff01 = 0; f0 = '0; f1 = '0;
    for (int c = 0; c < 4; c++) ones[c] = 0;
    mid_ready = 1'bx;
    while (bit_valid === 1'b1 && n < 300) begin
      for (int c = 0; c < 4; c++) ones[c] += int'(y[c]);
      if (n < 4) begin
        f0[n] = y[0]; f1[n] = y[1];
      end
      if (y[0] !== y[1]) diff01++;
      if (n == rst_at) rst = 1;
      if (mid && n == 10) begin
        ld_valid = 1; ld_ch = 2; ld_value = 8'd7;
        mid_ready = ld_ready;
      end
      n++;
      tick();
      ld_valid = 0;
      if (rst) begin
        rst = 0;
        break;
      end
    end
    if (n >= 300) begin
      total++;
      bad++;
      $error("FAIL frame_timeout n=%0d", n);
    end
  endtask

  initial begin
    rst = 1; start = 0; ld_valid = 0;
    ld_ch = 0; ld_value = 0;
    tick(); tick();
    rst = 0;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_y", y, 4'h0);
    chk("rst_ready", ld_ready, 1'b1);
    chk("rst_bv", bit_valid, 1'b0);

    frame(0, 0, 0, -1);
    chk("zero_len", n, 255);
    chk("zero_ones", ones[0] + ones[1] + ones[2] + ones[3], 0);
    chk("zero_done", done, 1'b1);
    tick();
    chk("zero_done_1cyc", done, 1'b0);

    load(0, 8'd0); load(1, 8'd1);
    load(2, 8'd128); load(3, 8'd255);
    frame(0, 0, 0, -1);
    chk("mix_len", n, 255);
    chk("mix_done256", done, 1'b1);
    chk("mix_ch0", ones[0], 0);
    chk("mix_ch1", ones[1], 1);
    chk("mix_ch2", ones[2], 128);
    chk("mix_ch3", ones[3], 255);
`ifdef SNG_POPCOUNT_EN
    chk("pc_done", ones_cnt, {8'd255, 8'd128, 8'd1, 8'd0});
    tick(); tick();
    chk("pc_hold", ones_cnt, {8'd255, 8'd128, 8'd1, 8'd0});
`else
    tick(); tick();
`endif
    chk("idle_ready", ld_ready, 1'b1);

    frame(1, 8'd64, 1, -1);
    chk("ldst_ch2", ones[2], 64);
    chk("ldst_len", n, 255);
    chk("run_ready", mid_ready, 1'b0);
    tick();
    frame(0, 0, 0, -1);
    chk("frozen_ch2", ones[2], 64);
    tick();

    load(0, 8'd100); load(1, 8'd100);
    frame(0, 0, 0, -1);
    chk("eq_ch0", ones[0], 100);
    chk("eq_ch1", ones[1], 100);
    chk("eq_differ", diff01 > 0, 1'b1);
    chk("seed_ch0", f0, 4'b0011);
    chk("seed_ch1", f1, 4'b1100);
    tick();

    frame(0, 0, 0, 50);
    chk("rst_mid_bits", n, 51);
    chk("rstm_busy", busy, 1'b0);
    chk("rstm_y", y, 4'h0);
    chk("rstm_bv", bit_valid, 1'b0);
    chk("rstm_ready", ld_ready, 1'b1);
    frame(0, 0, 0, -1);
    chk("cleared_ch0", ones[0], 0);
    tick();
    load(0, 8'd100); load(1, 8'd100);
    frame(0, 0, 0, -1);
    chk("again_len", n, 255);
    chk("again_ch0", f0, 4'b0011);
    chk("again_ch1", f1, 4'b1100);
    chk("again_ones", ones[0], 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
